// File: rtl/lwc_host_tx.sv
// lwc_host_tx: turns one host command into the LWC instruction/segment word stream.
//   Key load goes out on sdi; opcode, nonce, AD, message and tag go out on pdi.
//   Core output is forwarded to the host unbuffered; done/status_ok report the final status word.
// Ports: clk/rst; cmd_* handshake with key/npub; src_* host data in; pdi_*/sdi_* to core;
//   do_* from core; out_* to host; done pulse; status_ok held until the next done.
module lwc_host_tx (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_decrypt,
   input  logic         cmd_newkey,
   input  logic [15:0]  cmd_ad_len,
   input  logic [15:0]  cmd_msg_len,
   input  logic [127:0] key,
   input  logic [127:0] npub,
   input  logic [31:0]  src_data,
   input  logic         src_valid,
   output logic         src_ready,
   output logic [31:0]  pdi_data,
   output logic         pdi_valid,
   input  logic         pdi_ready,
   output logic [31:0]  sdi_data,
   output logic         sdi_valid,
   input  logic         sdi_ready,
   input  logic [31:0]  do_data,
   input  logic         do_valid,
   input  logic         do_last,
   output logic         do_ready,
   output logic [31:0]  out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         done,
   output logic         status_ok
);

   localparam logic [3:0] S_IDLE   = 4'd0,  S_LDKEY  = 4'd1,  S_KEYHDR = 4'd2,
                          S_KEYDAT = 4'd3,  S_ACTKEY = 4'd4,  S_OPCODE = 4'd5,
                          S_NPHDR  = 4'd6,  S_NPDAT  = 4'd7,  S_ADHDR  = 4'd8,
                          S_ADDAT  = 4'd9,  S_MSGHDR = 4'd10, S_MSGDAT = 4'd11,
                          S_TAGHDR = 4'd12, S_TAGDAT = 4'd13, S_WAIT   = 4'd14;

   localparam logic [3:0] OP_LDKEY = 4'h4, OP_ACTKEY = 4'h7, OP_ENC = 4'h2, OP_DEC = 4'h3;
   localparam logic [3:0] T_AD = 4'h1, T_PT = 4'h4, T_CT = 4'h5, T_TAG = 4'h8,
                          T_KEY = 4'hC, T_NPUB = 4'hD;

   // {type, Partial=0, EOI, EOT=1, Last, 8'h00, len}
   function automatic logic [31:0] seg_hdr(input logic [3:0] typ, input logic eoi,
                                           input logic last, input logic [15:0] len);
      return {typ, 1'b0, eoi, 1'b1, last, 8'h00, len};
   endfunction

   // ceil(len/4) with a 17-bit sum so 16'hFFFF yields 16384 rather than wrapping
   function automatic logic [15:0] num_words(input logic [15:0] len);
      return 16'(({1'b0, len} + 17'd3) >> 2);
   endfunction

   logic [3:0]   state_q, state_d;
   logic [15:0]  cnt_q, cnt_d;
   logic         dec_q, dec_d;
   logic [15:0]  ad_len_q, ad_len_d, msg_len_q, msg_len_d;
   logic [127:0] key_q, key_d, npub_q, npub_d;
   logic         seen_q, seen_d;
   logic         done_q, status_q;

   logic [15:0]  hdr_words;
   logic         pdi_fire, sdi_fire, last_fire;
   logic         eoi_np, eoi_ad, eoi_msg;

   // EOI lands on the last non-empty input segment, falling back to the nonce
   assign eoi_np  = (ad_len_q == 16'd0) && (msg_len_q == 16'd0);
   assign eoi_ad  = (ad_len_q != 16'd0) && (msg_len_q == 16'd0);
   assign eoi_msg = (msg_len_q != 16'd0);

   assign pdi_fire  = pdi_valid & pdi_ready;
   assign sdi_fire  = sdi_valid & sdi_ready;
   assign last_fire = do_valid & out_ready & do_last;

   assign cmd_ready = (state_q == S_IDLE);
   assign out_data  = do_data;
   assign out_valid = do_valid;
   assign do_ready  = out_ready;
   assign done      = done_q;
   assign status_ok = status_q;

   // Word presented in each state; purely a function of state and latched fields so it
   // stays stable until the port accepts it.
   always_comb begin
      pdi_data  = 32'h0;
      pdi_valid = 1'b0;
      sdi_data  = 32'h0;
      sdi_valid = 1'b0;
      src_ready = 1'b0;
      hdr_words = 16'd0;
      case (state_q)
         S_LDKEY:  begin sdi_data = {OP_LDKEY, 28'h0}; sdi_valid = 1'b1; end
         S_KEYHDR: begin
            sdi_data = seg_hdr(T_KEY, 1'b0, 1'b0, 16'd16); sdi_valid = 1'b1; hdr_words = 16'd4;
         end
         S_KEYDAT: begin sdi_data = key_q[127:96]; sdi_valid = 1'b1; end
         S_ACTKEY: begin pdi_data = {OP_ACTKEY, 28'h0}; pdi_valid = 1'b1; end
         S_OPCODE: begin pdi_data = {(dec_q ? OP_DEC : OP_ENC), 28'h0}; pdi_valid = 1'b1; end
         S_NPHDR:  begin
            pdi_data = seg_hdr(T_NPUB, eoi_np, 1'b0, 16'd16); pdi_valid = 1'b1; hdr_words = 16'd4;
         end
         S_NPDAT:  begin pdi_data = npub_q[127:96]; pdi_valid = 1'b1; end
         S_ADHDR:  begin
            pdi_data  = seg_hdr(T_AD, eoi_ad, 1'b0, ad_len_q);
            pdi_valid = 1'b1;
            hdr_words = num_words(ad_len_q);
         end
         S_MSGHDR: begin
            pdi_data  = seg_hdr(dec_q ? T_CT : T_PT, eoi_msg, ~dec_q, msg_len_q);
            pdi_valid = 1'b1;
            hdr_words = num_words(msg_len_q);
         end
         S_TAGHDR: begin
            pdi_data = seg_hdr(T_TAG, 1'b0, 1'b1, 16'd16); pdi_valid = 1'b1; hdr_words = 16'd4;
         end
         S_ADDAT, S_MSGDAT, S_TAGDAT: begin
            pdi_data  = src_data;
            pdi_valid = src_valid;
            src_ready = pdi_ready;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dec_d     = dec_q;
      ad_len_d  = ad_len_q;
      msg_len_d = msg_len_q;
      key_d     = key_q;
      npub_d    = npub_q;
      seen_d    = seen_q;
      case (state_q)
         S_IDLE: if (cmd_valid) begin
            dec_d     = cmd_decrypt;
            ad_len_d  = cmd_ad_len;
            msg_len_d = cmd_msg_len;
            key_d     = key;
            npub_d    = npub;
            seen_d    = 1'b0;
            state_d   = cmd_newkey ? S_LDKEY : S_OPCODE;
         end
         S_LDKEY:  if (sdi_fire) state_d = S_KEYHDR;
         S_KEYHDR: if (sdi_fire) begin cnt_d = hdr_words; state_d = S_KEYDAT; end
         S_KEYDAT: if (sdi_fire) begin
            key_d = {key_q[95:0], 32'h0};
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = S_ACTKEY;
         end
         S_ACTKEY: if (pdi_fire) state_d = S_OPCODE;
         S_OPCODE: if (pdi_fire) state_d = S_NPHDR;
         S_NPHDR:  if (pdi_fire) begin cnt_d = hdr_words; state_d = S_NPDAT; end
         S_NPDAT:  if (pdi_fire) begin
            npub_d = {npub_q[95:0], 32'h0};
            cnt_d  = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = S_ADHDR;
         end
         S_ADHDR: if (pdi_fire) begin
            cnt_d   = hdr_words;
            state_d = (hdr_words == 16'd0) ? S_MSGHDR : S_ADDAT;
         end
         S_ADDAT: if (pdi_fire) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = S_MSGHDR;
         end
         S_MSGHDR: if (pdi_fire) begin
            cnt_d = hdr_words;
            if (hdr_words != 16'd0) state_d = S_MSGDAT;
            else                    state_d = dec_q ? S_TAGHDR : S_WAIT;
         end
         S_MSGDAT: if (pdi_fire) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = dec_q ? S_TAGHDR : S_WAIT;
         end
         S_TAGHDR: if (pdi_fire) begin cnt_d = hdr_words; state_d = S_TAGDAT; end
         S_TAGDAT: if (pdi_fire) begin
            cnt_d = cnt_q - 16'd1;
            if (cnt_q == 16'd1) state_d = S_WAIT;
         end
         S_WAIT: if (seen_q || last_fire) begin
            seen_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // The core may finish before the input stream does; remember it so WAIT exits at once.
      if (last_fire && (state_q != S_IDLE) && (state_q != S_WAIT)) seen_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         dec_q     <= 1'b0;
         ad_len_q  <= 16'd0;
         msg_len_q <= 16'd0;
         key_q     <= 128'h0;
         npub_q    <= 128'h0;
         seen_q    <= 1'b0;
         done_q    <= 1'b0;
         status_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dec_q     <= dec_d;
         ad_len_q  <= ad_len_d;
         msg_len_q <= msg_len_d;
         key_q     <= key_d;
         npub_q    <= npub_d;
         seen_q    <= seen_d;
         done_q    <= last_fire;
         if (last_fire) status_q <= (do_data[31:28] == 4'hE);
      end
   end

endmodule

// File: tb/tb_lwc_host_tx.sv
// tb_lwc_host_tx: scoreboard bench for lwc_host_tx.
//   Expected pdi/sdi/out words and final status are queued when a command is issued;
//   a separate monitor pops and compares on every accepted word and on each done pulse.
module tb_lwc_host_tx;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid, cmd_ready, cmd_decrypt, cmd_newkey;
   logic [15:0]  cmd_ad_len, cmd_msg_len;
   logic [127:0] key, npub;
   logic [31:0]  src_data;
   logic         src_valid, src_ready;
   logic [31:0]  pdi_data, sdi_data, do_data, out_data;
   logic         pdi_valid, pdi_ready, sdi_valid, sdi_ready;
   logic         do_valid, do_last, do_ready, out_valid, out_ready;
   logic         done, status_ok;

   lwc_host_tx dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
      .cmd_newkey(cmd_newkey), .cmd_ad_len(cmd_ad_len), .cmd_msg_len(cmd_msg_len),
      .key(key), .npub(npub),
      .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
      .pdi_data(pdi_data), .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
      .sdi_data(sdi_data), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
      .do_data(do_data), .do_valid(do_valid), .do_last(do_last), .do_ready(do_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .done(done), .status_ok(status_ok)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int mode   = 0;   // 0: all ready, 1: pdi/sdi_ready toggling, 2: random ready
   logic [31:0]  exp_pdi[$], exp_sdi[$], exp_out[$], src_q[$];
   bit           exp_stat[$];
   logic [127:0] key_v, npub_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name, input int left);
      checks++;
      errors++;
      $display("FAIL %s: timed out with %0d items outstanding", name, left);
   endtask

   // ---------------- reference model: word stream from the protocol rules ----------------
   function automatic logic [31:0] hdr(input logic [3:0] typ, input bit eoi, input bit last,
                                       input logic [15:0] len);
      return {typ, 1'b0, eoi, 1'b1, last, 8'h00, len};
   endfunction

   task automatic push_src(input int n);
      logic [31:0] r;
      for (int i = 0; i < n; i++) begin
         r = $urandom;
         src_q.push_back(r);
         exp_pdi.push_back(r);
      end
   endtask

   task automatic model(input bit dec, input bit nk, input int ad, input int msg);
      int eoi_seg;   // 0 nonce, 1 AD, 2 message
      eoi_seg = (msg > 0) ? 2 : ((ad > 0) ? 1 : 0);
      if (nk) begin
         exp_sdi.push_back(32'h4000_0000);
         exp_sdi.push_back(hdr(4'hC, 1'b0, 1'b0, 16'd16));
         for (int i = 0; i < 4; i++) exp_sdi.push_back(key_v[127-32*i -: 32]);
         exp_pdi.push_back(32'h7000_0000);
      end
      exp_pdi.push_back(dec ? 32'h3000_0000 : 32'h2000_0000);
      exp_pdi.push_back(hdr(4'hD, eoi_seg == 0, 1'b0, 16'd16));
      for (int i = 0; i < 4; i++) exp_pdi.push_back(npub_v[127-32*i -: 32]);
      exp_pdi.push_back(hdr(4'h1, eoi_seg == 1, 1'b0, 16'(ad)));
      push_src((ad + 3) / 4);
      exp_pdi.push_back(hdr(dec ? 4'h5 : 4'h4, eoi_seg == 2, !dec, 16'(msg)));
      push_src((msg + 3) / 4);
      if (dec) begin
         exp_pdi.push_back(hdr(4'h8, 1'b0, 1'b1, 16'd16));
         push_src(4);
      end
   endtask

   // ---------------- drivers ----------------
   initial begin
      pdi_ready = 1'b0; sdi_ready = 1'b0; out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (mode)
            0: begin pdi_ready = 1'b1; sdi_ready = 1'b1; end
            1: begin pdi_ready = ~pdi_ready; sdi_ready = ~sdi_ready; end
            default: begin pdi_ready = 1'($urandom_range(0, 1)); sdi_ready = 1'($urandom_range(0, 1)); end
         endcase
         out_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : src_drv
      bit acc;
      src_valid = 1'b0; src_data = 32'h0;
      forever begin
         @(negedge clk);
         acc = src_valid && src_ready;
         @(posedge clk); #1;
         if (acc && src_q.size() > 0) begin
            void'(src_q.pop_front());
            src_valid = 1'b0;
         end
         if (!src_valid && src_q.size() > 0 && (mode == 0 || $urandom_range(0, 1) == 1)) begin
            src_valid = 1'b1;
            src_data  = src_q[0];
         end
         if (src_q.size() == 0) src_valid = 1'b0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      bit          prev_stall, exp_done_next;
      logic [31:0] prev_dat;
      prev_stall = 1'b0; exp_done_next = 1'b0; prev_dat = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0; exp_done_next = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("pdi_hold_valid", {31'h0, pdi_valid}, 32'h1);
               chk("pdi_hold_data", pdi_data, prev_dat);
            end
            if (pdi_valid && pdi_ready) begin
               if (exp_pdi.size() == 0) timeout("pdi_extra_word", 0);
               else chk("pdi_word", pdi_data, exp_pdi.pop_front());
            end
            if (sdi_valid && sdi_ready) begin
               if (exp_sdi.size() == 0) timeout("sdi_extra_word", 0);
               else chk("sdi_word", sdi_data, exp_sdi.pop_front());
            end
            if (do_valid) begin
               chk("out_valid_pass", {31'h0, out_valid}, 32'h1);
               chk("do_ready_pass", {31'h0, do_ready}, {31'h0, out_ready});
               chk("out_data_pass", out_data, do_data);
            end
            if (out_valid && out_ready) begin
               if (exp_out.size() == 0) timeout("out_extra_word", 0);
               else chk("out_word", out_data, exp_out.pop_front());
            end
            if (exp_done_next) begin
               chk("done_pulse", {31'h0, done}, 32'h1);
               if (exp_stat.size() == 0) timeout("status_extra", 0);
               else chk("status_ok", {31'h0, status_ok}, {31'h0, exp_stat.pop_front()});
            end else if (done) begin
               timeout("done_unexpected", 0);
            end
            exp_done_next = do_valid && do_ready && do_last;
            prev_stall    = pdi_valid && !pdi_ready;
            prev_dat      = pdi_data;
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   // ---------------- sequencing tasks ----------------
   task automatic issue_cmd(input bit dec, input bit nk, input logic [15:0] ad, input logic [15:0] msg);
      int n;
      @(posedge clk); #1;
      cmd_decrypt = dec; cmd_newkey = nk; cmd_ad_len = ad; cmd_msg_len = msg;
      key = key_v; npub = npub_v; cmd_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!cmd_ready && n < 500);
      if (!cmd_ready) timeout("cmd_accept", 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      key = ~key_v; npub = ~npub_v;   // latched copies must be used from here on
   endtask

   task automatic send_do(input logic [31:0] status);
      int n;
      @(posedge clk); #1;
      exp_stat.push_back(status[31:28] == 4'hE);
      for (int i = 0; i < 2; i++) begin
         do_data  = (i == 0) ? $urandom : status;
         do_last  = (i == 1);
         do_valid = 1'b1;
         exp_out.push_back(do_data);
         n = 0;
         do begin @(negedge clk); n++; end while (!do_ready && n < 500);
         if (!do_ready) timeout("do_accept", 2 - i);
         @(posedge clk); #1;
      end
      do_valid = 1'b0; do_last = 1'b0;
   endtask

   task automatic run_cmd(input bit dec, input bit nk, input logic [15:0] ad, input logic [15:0] msg,
                          input logic [31:0] status, input bit early);
      int n;
      issue_cmd(dec, nk, ad, msg);
      if (early) send_do(status);
      n = 0;
      while ((exp_pdi.size() != 0 || exp_sdi.size() != 0) && n < 40000) begin
         @(negedge clk); n++;
      end
      if (n >= 40000) timeout("stream_drain", exp_pdi.size() + exp_sdi.size());
      if (!early) send_do(status);
      n = 0;
      while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
      chk("back_to_idle", {31'h0, cmd_ready}, 32'h1);
      repeat (3) @(negedge clk);
      chk("done_seen", exp_stat.size(), 32'h0);
      chk("out_drained", exp_out.size(), 32'h0);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      bit          dec, nk;
      int          ad, msg, n;
      logic [31:0] st;
      rst = 1'b1; cmd_valid = 1'b0; cmd_decrypt = 1'b0; cmd_newkey = 1'b0;
      cmd_ad_len = 16'h0; cmd_msg_len = 16'h0; key = 128'h0; npub = 128'h0;
      do_data = 32'h0; do_valid = 1'b0; do_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("rst_pdi_valid", {31'h0, pdi_valid}, 32'h0);
      chk("rst_sdi_valid", {31'h0, sdi_valid}, 32'h0);
      chk("rst_src_ready", {31'h0, src_ready}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_status_ok", {31'h0, status_ok}, 32'h0);
      @(posedge clk); #1 rst = 1'b0;

      // ENC with key load, ad=5, msg=8; then the same stream under toggling ready
      key_v  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      npub_v = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
      for (int pass = 0; pass < 2; pass++) begin
         mode    = pass;
         exp_sdi = '{32'h4000_0000, 32'hC200_0010, 32'h0011_2233, 32'h4455_6677,
                     32'h8899_AABB, 32'hCCDD_EEFF};
         exp_pdi = '{32'h7000_0000, 32'h2000_0000, 32'hD200_0010, 32'hA0A1_A2A3,
                     32'hB0B1_B2B3, 32'hC0C1_C2C3, 32'hD0D1_D2D3, 32'h1200_0005,
                     32'h1111_0001, 32'h1111_0002, 32'h4700_0008, 32'h2222_0001, 32'h2222_0002};
         src_q   = '{32'h1111_0001, 32'h1111_0002, 32'h2222_0001, 32'h2222_0002};
         run_cmd(1'b0, 1'b1, 16'd5, 16'd8, 32'hE123_4567, 1'b0);
      end

      // DEC without key, empty AD and message, failing status
      mode    = 0;
      exp_pdi = '{32'h3000_0000, 32'hD600_0010, 32'hA0A1_A2A3, 32'hB0B1_B2B3,
                  32'hC0C1_C2C3, 32'hD0D1_D2D3, 32'h1200_0000, 32'h5200_0000,
                  32'h8300_0010, 32'h7A70_0001, 32'h7A70_0002, 32'h7A70_0003, 32'h7A70_0004};
      src_q   = '{32'h7A70_0001, 32'h7A70_0002, 32'h7A70_0003, 32'h7A70_0004};
      run_cmd(1'b1, 1'b0, 16'd0, 16'd0, 32'hF000_0000, 1'b0);

      // ENC ad=0, msg=3, passing status
      exp_pdi = '{32'h2000_0000, 32'hD200_0010, 32'hA0A1_A2A3, 32'hB0B1_B2B3,
                  32'hC0C1_C2C3, 32'hD0D1_D2D3, 32'h1200_0000, 32'h4700_0003, 32'h5555_AAAA};
      src_q   = '{32'h5555_AAAA};
      run_cmd(1'b0, 1'b0, 16'd0, 16'd3, 32'hE000_0000, 1'b0);

      // Reset in the middle of AD data
      model(1'b0, 1'b0, 40, 4);
      issue_cmd(1'b0, 1'b0, 16'd40, 16'd4);
      n = 0;
      while (exp_pdi.size() > 8 && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) timeout("reach_addat", exp_pdi.size());
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_pdi_valid", {31'h0, pdi_valid}, 32'h0);
      chk("mid_rst_src_ready", {31'h0, src_ready}, 32'h0);
      exp_pdi.delete(); src_q.delete(); src_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("post_rst_pdi_valid", {31'h0, pdi_valid}, 32'h0);
      chk("post_rst_status_ok", {31'h0, status_ok}, 32'h0);
      chk("post_rst_done", {31'h0, done}, 32'h0);

      // Randomized commands against the model; odd runs deliver the core's last word early
      for (int t = 0; t < 9; t++) begin
         dec    = 1'($urandom);
         nk     = (t == 0) ? 1'b1 : 1'($urandom);
         ad     = $urandom_range(0, 13);
         msg    = $urandom_range(0, 13);
         key_v  = {$urandom, $urandom, $urandom, $urandom};
         npub_v = {$urandom, $urandom, $urandom, $urandom};
         st     = {($urandom_range(0, 1) == 1) ? 4'hE : 4'h3, 28'($urandom)};
         mode   = t % 3;
         model(dec, nk, ad, msg);
         run_cmd(dec, nk, 16'(ad), 16'(msg), st, (t % 2) == 1);
      end

      // Largest AD length: 16384 words, no wrap in the word count
      mode = 0;
      model(1'b0, 1'b0, 65535, 0);
      run_cmd(1'b0, 1'b0, 16'hFFFF, 16'd0, 32'hE000_0001, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lwc_host_tx.md
LWC_HOST_TX -- requirements
Module: lwc_host_tx

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous reset, active-high.
REQ-002 SHALL have ports: cmd_valid in 1, cmd_ready out 1 (command handshake); cmd_decrypt in 1 (1=DEC, 0=ENC); cmd_newkey in 1 (load key first); cmd_ad_len in 16 (AD bytes); cmd_msg_len in 16 (PT/CT bytes).
REQ-003 SHALL have ports: key in 128 (key, word 0 = bits 127:96); npub in 128 (nonce, same ordering).
REQ-004 SHALL have ports: src_data in 32, src_valid in 1, src_ready out 1 (AD, message, then tag words from host).
REQ-005 SHALL have ports: pdi_data out 32, pdi_valid out 1, pdi_ready in 1; sdi_data out 32, sdi_valid out 1, sdi_ready in 1 (to core).
REQ-006 SHALL have ports: do_data in 32, do_valid in 1, do_last in 1, do_ready out 1 (from core); out_data out 32, out_valid out 1, out_ready in 1 (to host); done out 1; status_ok out 1.

Function
REQ-007 Instruction word SHALL be {opcode[3:0], 28'h0}: LDKEY=4'h4, ACTKEY=4'h7, ENC=4'h2, DEC=4'h3.
REQ-008 Segment header SHALL be {type[3:0], Partial=0, EOI, EOT=1, Last, 8'h00, len[15:0]}: AD=4'h1, PT=4'h4, CT=4'h5, TAG=4'h8, KEY=4'hC, NPUB=4'hD.
REQ-009 Data words per segment SHALL be ceil(len/4) (len+3 >> 2, 17-bit intermediate, no overflow at 16'hFFFF); len=0 sends the header only.
REQ-010 cmd_ready SHALL be 1 only in IDLE; command fields, key, npub latched on cmd_valid&cmd_ready.
REQ-011 FSM states: IDLE, LDKEY, KEYHDR, KEYDAT, ACTKEY, OPCODE, NPHDR, NPDAT, ADHDR, ADDAT, MSGHDR, MSGDAT, TAGHDR, TAGDAT, WAIT.
REQ-012 Sequence: IDLE -> (newkey ? LDKEY -> KEYHDR(len 16) -> KEYDAT(4 words) -> ACTKEY : OPCODE) -> NPHDR(len 16) -> NPDAT(4) -> ADHDR -> ADDAT -> MSGHDR -> MSGDAT -> (decrypt ? TAGHDR(len 16) -> TAGDAT(4) : -) -> WAIT -> IDLE.
REQ-013 LDKEY, KEYHDR, KEYDAT SHALL drive sdi; all other send states drive pdi; ACTKEY SHALL be followed by OPCODE on pdi.
REQ-014 A word SHALL advance only on valid&ready of its port; valid and data SHALL hold stable until accepted.
REQ-015 ADDAT/MSGDAT/TAGDAT: pdi_data=src_data, pdi_valid=src_valid, src_ready=pdi_ready; src_ready=0 in all other states.
REQ-016 EOI=1 on exactly one of NPUB (ad=msg=0), AD (msg=0, ad>0), MSG (msg>0); 0 elsewhere; KEY and TAG EOI=0.
REQ-017 Last=1 on MSG header for ENC, on TAG header for DEC; 0 on all other headers.
REQ-018 Word counter SHALL be 16-bit, loaded at each header accept, decremented per data accept; header with count 0 skips data state.
REQ-019 do path: out_data=do_data, out_valid=do_valid, do_ready=out_ready in every state (pass-through, no buffering).
REQ-020 On do_valid&do_ready&do_last: done SHALL pulse 1 cycle next clock; status_ok registered as (do_data[31:28]==4'hE), held until next done.
REQ-021 WAIT SHALL exit to IDLE on the do_last acceptance; do_last arriving before WAIT SHALL be recorded and WAIT exits on entry.
REQ-022 Simultaneous cmd_valid and done: no command accepted that cycle (cmd_ready=0 outside IDLE).

Reset
REQ-023 rst=1 SHALL asynchronously force IDLE, counter=0, recorded-last=0, pdi_valid=0, sdi_valid=0, src_ready=0, done=0, status_ok=0, cmd_ready=1 on release.
REQ-024 Reset mid-transfer SHALL abandon the sequence; no partial word reasserted after release.

Verification
REQ-025 ENC newkey, ad=5, msg=8, all ready=1 -> sdi: 40000000, C2000010, 4 key words; pdi: 70000000, 20000000, D2000010, 4 npub, 12000005, 2 words, 47000008, 2 words.
REQ-026 DEC no key, ad=0, msg=0 -> pdi: 30000000, D6000010, 4 npub, 12000000, 52000000, 83000010, 4 tag words; do status F0000000 with do_last -> done pulse, status_ok=0.
REQ-027 ENC ad=0, msg=3 -> AD header 12000000, MSG header 47000003, one data word; status E0000000 -> status_ok=1.
REQ-028 pdi_ready toggling 1/0 each cycle, src_valid random -> word order and values identical to REQ-025, no duplicated or dropped words.
REQ-029 rst pulsed during ADDAT -> pdi_valid=0 same cycle, cmd_ready=1 after release, next command starts clean at OPCODE/LDKEY.
